// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the fighter sprite fetch path
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOP    = 2'd1,
        ONESHOT = 2'd2,
        DONE    = 2'd3
    } anim_state_t;

    localparam int H_ACTIVE                = 640;
    localparam int V_ACTIVE                = 480;
    localparam int DEFAULT_TRANSPARENT_IDX = 1;

    // Bit width needed to count 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - animation frame sequencer with loop and one-shot modes
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_tick,
    input  logic                            anim_start,
    input  logic                            anim_mode,
    output logic [width_of(NUM_FRAMES)-1:0] anim_frame,
    output logic                            anim_done
);

    localparam int FW = width_of(NUM_FRAMES);
    localparam int HW = width_of(FRAME_HOLD);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
    localparam logic [HW-1:0] LAST_HOLD  = HW'(FRAME_HOLD - 1);

    anim_state_t   state, state_nx;
    logic [HW-1:0] hold, hold_nx;
    logic [FW-1:0] frame, frame_nx;

    // State, hold counter and frame number registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            hold  <= '0;
            frame <= '0;
        end else begin
            state <= state_nx;
            hold  <= hold_nx;
            frame <= frame_nx;
        end
    end

    // Next-state logic: anim_start overrides everything, including a coincident tick.
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        frame_nx = frame;
        if (anim_start) begin
            state_nx = anim_mode ? ONESHOT : LOOP;
            hold_nx  = '0;
            frame_nx = '0;
        end else begin
            case (state)
                LOOP, ONESHOT: begin
                    if (frame_tick) begin
                        if (hold == LAST_HOLD) begin
                            hold_nx = '0;
                            if (frame == LAST_FRAME) begin
                                frame_nx = '0;
                            end else begin
                                frame_nx = frame + FW'(1);
                            end
                            if (state == ONESHOT && frame_nx == LAST_FRAME) begin
                                state_nx = DONE;
                            end
                        end else begin
                            hold_nx = hold + HW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    assign anim_frame = frame;
    assign anim_done  = (state == DONE);

endmodule

// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - sprite hit test, ROM addressing and two-stage palette index pipeline
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int SPRITE_W        = 64,
    parameter int SPRITE_H        = 96,
    parameter int NUM_FRAMES      = 4,
    parameter int FRAME_HOLD      = 8,
    parameter int TRANSPARENT_IDX = DEFAULT_TRANSPARENT_IDX,
    parameter int ADDR_W          = 15
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic [9:0]                      sprite_x,
    input  logic [9:0]                      sprite_y,
    input  logic                            facing_left,
    input  logic                            frame_tick,
    input  logic                            anim_start,
    input  logic                            anim_mode,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [3:0]                      rom_data,
    output logic [3:0]                      pal_index,
    output logic                            sprite_on,
    output logic [width_of(NUM_FRAMES)-1:0] anim_frame,
    output logic                            anim_done
);

    logic [10:0]       x_end, y_end;
    logic              hit;
    logic [9:0]        dx, dy;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_nx;
    logic              hit_q1, hit_q2;

    sprite_anim_ctrl #(
        .NUM_FRAMES(NUM_FRAMES),
        .FRAME_HOLD(FRAME_HOLD)
    ) u_anim (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .anim_start(anim_start),
        .anim_mode (anim_mode),
        .anim_frame(anim_frame),
        .anim_done (anim_done)
    );

    // Box test in 11 bits so a sprite hanging past column/row 1023 does not wrap around.
    always_comb begin
        x_end = {1'b0, sprite_x} + 11'(SPRITE_W);
        y_end = {1'b0, sprite_y} + 11'(SPRITE_H);
        hit   = ({1'b0, DrawX} >= {1'b0, sprite_x}) && ({1'b0, DrawX} < x_end) &&
                ({1'b0, DrawY} >= {1'b0, sprite_y}) && ({1'b0, DrawY} < y_end);
    end

    // ROM address: frame base + row offset + (optionally mirrored) column, modulo 2^ADDR_W.
    always_comb begin
        dx      = DrawX - sprite_x;
        dy      = DrawY - sprite_y;
        col     = facing_left ? (ADDR_W'(SPRITE_W - 1) - ADDR_W'(dx)) : ADDR_W'(dx);
        addr_nx = ADDR_W'(anim_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
                + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
                + col;
    end

    // Stage 1 registers the address; stage 2 keeps the hit flag aligned with ROM output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            hit_q1   <= 1'b0;
            hit_q2   <= 1'b0;
        end else begin
            rom_addr <= addr_nx;
            hit_q1   <= hit;
            hit_q2   <= hit_q1;
        end
    end

    assign pal_index = rom_data;
    assign sprite_on = hit_q2 && (rom_data != 4'(TRANSPARENT_IDX));

endmodule
